// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI byte slave: frame width, counter widths, rx FIFO geometry.
package spi_pkg;
  localparam int SPI_BITS = 8;
  localparam int BIT_CNT_W = 3;
  localparam logic [SPI_BITS-1:0] FILL_BYTE_DEFAULT = 8'h00;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_e;

  typedef struct packed {
    logic                first;
    logic [SPI_BITS-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/spi_slave_byte_if.sv
// Byte-stream side of the SPI slave: rx valid/ready stream, tx valid/ready stream and status pulses.
interface spi_slave_byte_if;
  logic [spi_pkg::SPI_BITS-1:0] rx_data;
  logic                         rx_valid;
  logic                         rx_first;
  logic                         rx_ready;
  logic [spi_pkg::SPI_BITS-1:0] tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         tx_underrun;
  logic                         rx_overrun;

  modport slave (
    output rx_data, rx_valid, rx_first, tx_ready, tx_underrun, rx_overrun,
    input  rx_ready, tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, rx_first, tx_ready, tx_underrun, rx_overrun,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous pin, with registered level and rise/fall strobes
// that are aligned with each other (all three change on the same clock edge).
module spi_sync #(
  parameter int STAGES = 2,
  parameter bit IDLE   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain <= {STAGES{IDLE}};
      level <= IDLE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave: synchronises SS/SCK/MOSI, deserialises MOSI and serialises queued replies on MISO.
// Define SPI_SLAVE_RX_FIFO_EN to route received bytes through a 4-entry FIFO with rx_ready backpressure.
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spi_ss,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_slave_byte_if.slave bus
);
  logic       ss_lvl, ss_rise, ss_fall, sck_rise, sck_fall, mosi_lvl;
  logic       unused_sck_lvl;
  logic [1:0] unused_mosi_edges;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_ss_sync (
    .clk_i, .rst_i, .d(spi_ss), .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sck_sync (
    .clk_i, .rst_i, .d(spi_sck), .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_mosi_sync (
    .clk_i, .rst_i, .d(spi_mosi), .level(mosi_lvl),
    .rise(unused_mosi_edges[0]), .fall(unused_mosi_edges[1])
  );

  spi_state_e           state;
  logic [SYNC_STAGES:0] settle;
  logic                 armed, first_pending, byte_done, tx_full, underrun_q;
  logic                 rx_push, rx_byte_first;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [SPI_BITS-1:0]  rx_shift, rx_next, rx_byte, tx_shift, tx_buf;
  logic                 start, load, accept;

  assign rx_next = {rx_shift[SPI_BITS-2:0], mosi_lvl};
  assign start   = (state == ST_IDLE) && armed && ss_fall;
  assign load    = start || ((state == ST_ACTIVE) && !ss_rise && sck_fall && byte_done);
  assign accept  = bus.tx_valid && !tx_full;

  assign spi_miso        = tx_shift[SPI_BITS-1];
  assign bus.tx_ready    = !tx_full;
  assign bus.tx_underrun = underrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      settle        <= '0;
      armed         <= 1'b0;
      first_pending <= 1'b0;
      byte_done     <= 1'b0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      rx_byte       <= '0;
      rx_byte_first <= 1'b0;
      rx_push       <= 1'b0;
      tx_shift      <= '0;
      tx_buf        <= '0;
      tx_full       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      settle     <= {settle[SYNC_STAGES-1:0], 1'b1};
      rx_push    <= 1'b0;
      underrun_q <= 1'b0;
      case (state)
        // SS must be seen high through a flushed synchroniser before a fall can open a frame.
        ST_IDLE: begin
          armed <= settle[SYNC_STAGES] & ss_lvl;
          if (start) begin
            state         <= ST_ACTIVE;
            armed         <= 1'b0;
            bit_cnt       <= '0;
            byte_done     <= 1'b0;
            first_pending <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            tx_shift  <= '0;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(SPI_BITS - 1)) begin
              rx_push       <= 1'b1;
              rx_byte       <= rx_next;
              rx_byte_first <= first_pending;
              first_pending <= 1'b0;
              byte_done     <= 1'b1;
            end
          end else if (sck_fall) begin
            byte_done <= 1'b0;
            if (!byte_done) tx_shift <= tx_shift << 1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        if (tx_full) begin
          tx_shift <= tx_buf;
        end else begin
          tx_shift   <= FILL_BYTE;
          underrun_q <= 1'b1;
        end
      end
      if (accept) tx_buf <= bus.tx_data;
      tx_full <= accept || (tx_full && !load);
    end
  end

`ifdef SPI_SLAVE_RX_FIFO_EN
  rx_entry_t               fifo_mem [FIFO_DEPTH];
  rx_entry_t               head;
  logic [FIFO_PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_PTR_W:0]     count;
  logic                    nonempty, full, pop, push_ok, overrun_q;

  assign nonempty = (count != '0);
  assign full     = (count == (FIFO_PTR_W + 1)'(FIFO_DEPTH));
  assign pop      = nonempty && bus.rx_ready;
  assign push_ok  = rx_push && (!full || pop);
  assign head     = fifo_mem[rd_ptr];

  // NOTE: storage needs no reset; an entry is only read after it has been written, and outputs are gated by nonempty.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= '{first: rx_byte_first, data: rx_byte};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= rx_push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.rx_valid   = nonempty;
  assign bus.rx_data    = nonempty ? head.data : '0;
  assign bus.rx_first   = nonempty & head.first;
  assign bus.rx_overrun = overrun_q;
`else
  logic unused_rx_ready;
  assign unused_rx_ready = bus.rx_ready;

  assign bus.rx_valid   = rx_push;
  assign bus.rx_data    = rx_byte;
  assign bus.rx_first   = rx_byte_first;
  assign bus.rx_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: stimulus pushes expected {first,data} into a queue, a monitor pops on rx handshakes.
`timescale 1ns/1ps
module tb_spi_slave_byte;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic spi_ss = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic spi_miso;

  spi_slave_byte_if bus();

  spi_slave_byte #(.SYNC_STAGES(2), .FILL_BYTE(8'h00)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .spi_ss(spi_ss), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0, bad = 0;
  int         underruns = 0, overruns = 0;
  logic       prev_valid = 1'b0;
  logic [8:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: counts status pulses and scores every rx handshake against the expected queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      underruns += int'(bus.tx_underrun);
      overruns  += int'(bus.rx_overrun);
`ifdef SPI_SLAVE_RX_FIFO_EN
      if (bus.rx_valid && bus.rx_ready) begin
`else
      if (bus.rx_valid) begin
        check("rx_single_pulse", 32'(prev_valid), 32'd0);
`endif
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected got=%0h want=none", {bus.rx_first, bus.rx_data});
        end else begin
          check("rx_byte", 32'({bus.rx_first, bus.rx_data}), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = bus.rx_valid;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic frame_start();
    spi_ss = 1'b0;
    clks(8);
  endtask

  // Mode 0, SCK = clk/8: MOSI changes with SCK low, MISO sampled at the rising edge.
  // When end_frame is set, SS rises together with the final SCK fall.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit end_frame, output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = mo[7-k];
      clks(4);
      mi[7-k] = spi_miso;
      spi_sck = 1'b1;
      clks(4);
      spi_sck = 1'b0;
      if (end_frame && k == nbits - 1) spi_ss = 1'b1;
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    int n = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("tx_accept", 32'(bus.tx_ready), 32'd1);
    @(negedge clk_i);
    bus.tx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_first", 32'(bus.rx_first), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    check("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mi;
    int         u0, o0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;

    clks(3);
    check_reset_outputs();
    rst_i = 1'b0;
    clks(10);

    // Single frame, nothing queued: fill byte out, one underrun at SS fall.
    u0 = underruns;
    exp_q.push_back({1'b1, 8'hA5});
    frame_start();
    xfer(8'hA5, 8, 1'b1, mi);
    check("t1_miso", 32'(mi), 32'h00);
    clks(10);
    check("t1_underruns", 32'(underruns - u0), 32'd1);
    check("t1_miso_idle", 32'(spi_miso), 32'd0);
    check("t1_rx_drained", 32'(exp_q.size()), 32'd0);

    // Queued 3C goes out first, then fill; tx_ready returns after the SS-fall load.
    tx_push(8'h3C);
    check("t2_tx_full", 32'(bus.tx_ready), 32'd0);
    u0 = underruns;
    exp_q.push_back({1'b1, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    frame_start();
    check("t2_tx_ready_after_load", 32'(bus.tx_ready), 32'd1);
    xfer(8'h01, 8, 1'b0, mi);
    check("t2_miso_b0", 32'(mi), 32'h3C);
    xfer(8'h02, 8, 1'b1, mi);
    check("t2_miso_b1", 32'(mi), 32'h00);
    clks(10);
    check("t2_underruns", 32'(underruns - u0), 32'd1);
    check("t2_rx_drained", 32'(exp_q.size()), 32'd0);

    // Aborted partial byte is discarded; the next frame restarts the bit counter.
    frame_start();
    xfer(8'hFF, 5, 1'b1, mi);
    clks(10);
    exp_q.push_back({1'b1, 8'h81});
    frame_start();
    xfer(8'h81, 8, 1'b1, mi);
    clks(10);
    check("t3_rx_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-byte with SS held low: no transfer until SS is seen high then low again.
    frame_start();
    tx_push(8'h77);
    xfer(8'hC3, 4, 1'b0, mi);
    rst_i = 1'b1;
    clks(3);
    check_reset_outputs();
    rst_i = 1'b0;
    clks(10);
    xfer(8'hEE, 8, 1'b0, mi);
    clks(10);
    check("t4_nothing_before_toggle", 32'(exp_q.size()), 32'd0);
    spi_ss = 1'b1;
    clks(10);
    exp_q.push_back({1'b1, 8'h5A});
    frame_start();
    xfer(8'h5A, 8, 1'b1, mi);
    check("t4_miso_buffer_cleared", 32'(mi), 32'h00);
    clks(10);
    check("t4_rx_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back replies across a 3-byte frame with no underrun.
    u0 = underruns;
    exp_q.push_back({1'b1, 8'hC1});
    exp_q.push_back({1'b0, 8'hC2});
    exp_q.push_back({1'b0, 8'hC3});
    fork
      begin
        tx_push(8'h11);
        tx_push(8'h22);
        tx_push(8'h33);
      end
      begin
        logic [7:0] m0, m1, m2;
        clks(6);
        frame_start();
        xfer(8'hC1, 8, 1'b0, m0);
        xfer(8'hC2, 8, 1'b0, m1);
        xfer(8'hC3, 8, 1'b1, m2);
        check("t5_miso_b0", 32'(m0), 32'h11);
        check("t5_miso_b1", 32'(m1), 32'h22);
        check("t5_miso_b2", 32'(m2), 32'h33);
      end
    join
    clks(10);
    check("t5_underruns", 32'(underruns - u0), 32'd0);
    check("t5_rx_drained", 32'(exp_q.size()), 32'd0);

`ifdef SPI_SLAVE_RX_FIFO_EN
    // FIFO fills with 10..13, 14 is dropped with one overrun, then drains in order.
    bus.rx_ready = 1'b0;
    o0 = overruns;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 8'(8'h10 + i)});
    frame_start();
    for (int i = 0; i < 5; i++) xfer(8'(8'h10 + i), 8, (i == 4), mi);
    clks(10);
    check("t6_overruns", 32'(overruns - o0), 32'd1);
    check("t6_head_valid", 32'(bus.rx_valid), 32'd1);
    check("t6_head", 32'({bus.rx_first, bus.rx_data}), 32'h110);
    bus.rx_ready = 1'b1;
    clks(10);
    check("t6_rx_drained", 32'(exp_q.size()), 32'd0);
    check("t6_empty", 32'(bus.rx_valid), 32'd0);
`else
    o0 = overruns;
    clks(4);
    check("no_fifo_overruns", 32'(overruns - o0), 32'd0);
`endif

    clks(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
